// File: rtl/pause_ctrl.sv
// Pause controller: debounced user pause toggle, external pause sources,
// and video dimming after a long pause.
module pause_ctrl #(
    parameter logic [31:0] DIM_CYCLES      = 32'h0E4E1C00,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1200
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       pause_btn,
    input  logic       osd_open,
    input  logic       osd_pause_en,
    input  logic       hs_access,
    input  logic [7:0] rgb_in,
    output logic       pause,
    output logic       pause_user,
    output logic       dim_video,
    output logic [7:0] rgb_out
);

    typedef enum logic [1:0] {
        RUN,
        PAUSED,
        DIMMED
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] timer_q;
    logic [31:0] timer_d;

    logic        sync1_q;
    logic        sync2_q;
    logic        deb_q;
    logic        edge_q;
    logic [15:0] cnt_q;
    logic        press;

    // The debounced level only moves after a long enough run of
    // disagreeing synchronized samples; any agreeing sample restarts it.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pause_btn;
            sync2_q <= sync1_q;
            edge_q  <= deb_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEBOUNCE_CYCLES) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign press = deb_q & ~edge_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            RUN: begin
                if (press) begin
                    state_d = PAUSED;
                    timer_d = '0;
                end
            end
            PAUSED: begin
                if (press) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q == DIM_CYCLES) begin
                    state_d = DIMMED;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 32'd1;
                end
            end
            DIMMED: begin
                if (press) begin
                    state_d = RUN;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = RUN;
                timer_d = '0;
            end
        endcase
    end

    assign pause_user = (state_q != RUN);
    assign dim_video  = (state_q == DIMMED);
    assign pause      = hs_access | pause_user
                      | (osd_open & osd_pause_en);

    // Dimming halves each channel by dropping its LSB.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rgb_out <= '0;
        end else if (dim_video) begin
            rgb_out <= {1'b0, rgb_in[7:6],
                        1'b0, rgb_in[4:3],
                        1'b0, rgb_in[1]};
        end else begin
            rgb_out <= rgb_in;
        end
    end

endmodule

// File: tb/tb_pause_ctrl.sv
// Testbench for pause_ctrl: directed scenarios plus randomized traffic
// compared against a history-based reference model.
module tb_pause_ctrl;

    localparam int DIM = 10;
    localparam int DEB = 4;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       pause_btn = 1'b0;
    logic       osd_open = 1'b0;
    logic       osd_pause_en = 1'b0;
    logic       hs_access = 1'b0;
    logic [7:0] rgb_in = 8'h00;
    logic       pause;
    logic       pause_user;
    logic       dim_video;
    logic [7:0] rgb_out;

    int checks = 0;
    int failures = 0;

    pause_ctrl #(
        .DIM_CYCLES     (32'd10),
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .pause_btn   (pause_btn),
        .osd_open    (osd_open),
        .osd_pause_en(osd_pause_en),
        .hs_access   (hs_access),
        .rgb_in      (rgb_in),
        .pause       (pause),
        .pause_user  (pause_user),
        .dim_video   (dim_video),
        .rgb_out     (rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: pin delayed two samples; level flips after DEB+1
    // consecutive samples disagreeing with it; mode 0 run, 1 paused, 2 dimmed.
    bit         m_s1, m_s2, m_lvl, m_prev;
    bit         m_hist[$];
    int         m_mode;
    int         m_tmr;
    logic [7:0] m_rgb;
    bit         m_ev, m_all;

    function automatic logic [7:0] dimpix(input logic [7:0] p);
        return {1'b0, p[7:6], 1'b0, p[4:3], 1'b0, p[1]};
    endfunction

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            m_hist.delete();
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0;
            m_mode = 0; m_tmr = 0; m_rgb = 8'h00;
        end else begin
            m_ev = m_lvl && !m_prev;
            m_rgb = (m_mode == 2) ? dimpix(rgb_in) : rgb_in;
            if (m_ev) begin
                m_mode = (m_mode == 0) ? 1 : 0;
                m_tmr = 0;
            end else if (m_mode == 1) begin
                if (m_tmr == DIM) m_mode = 2;
                else m_tmr = m_tmr + 1;
            end
            m_prev = m_lvl;
            m_hist.push_back(m_s2);
            if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
            if (m_hist.size() == DEB + 1) begin
                m_all = 1;
                foreach (m_hist[i]) if (m_hist[i] == m_lvl) m_all = 0;
                if (m_all) begin
                    m_lvl = m_s2;
                    m_hist.delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = pause_btn;
        end
    end

    task automatic step();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        rgb_in = 8'h5A;
        hs_access = 1'b1;
        step();
        checks++;
        if (pause_user !== 1'b0 || dim_video !== 1'b0 || rgb_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: pu=%b dim=%b rgb=%h required 0 0 00",
                     pause_user, dim_video, rgb_out);
        end
        checks++;
        if (pause !== 1'b1) begin
            failures++;
            $display("FAIL reset_pause_hs: pause=%b required 1", pause);
        end
        hs_access = 1'b0;
        #1;
        checks++;
        if (pause !== 1'b0) begin
            failures++;
            $display("FAIL reset_pause_idle: pause=%b required 0", pause);
        end
        rgb_in = 8'h00;
        reset_n = 1'b1;
    endtask

    task automatic test_press_dim();
        do_reset();
        rgb_in = 8'hFF;
        pause_btn = 1'b1;
        for (int k = 0; k < 26; k++) begin
            step();
            if (k == 19) pause_btn = 1'b0;
            checks++;
            if (pause_user !== (k >= 7)) begin
                failures++;
                $display("FAIL press_pu k=%0d: pu=%b required %b",
                         k, pause_user, (k >= 7));
            end
            checks++;
            if (dim_video !== (k >= 18)) begin
                failures++;
                $display("FAIL press_dim k=%0d: dim=%b required %b",
                         k, dim_video, (k >= 18));
            end
            if (k == 18 || k == 19) begin
                checks++;
                if (rgb_out !== ((k == 19) ? 8'h6D : 8'hFF)) begin
                    failures++;
                    $display("FAIL press_rgb k=%0d: rgb=%h required %h",
                             k, rgb_out, (k == 19) ? 8'h6D : 8'hFF);
                end
            end
        end
    endtask

    task automatic test_unpause();
        rgb_in = 8'hA5;
        pause_btn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (pause_user !== (k < 7) || dim_video !== (k < 7)) begin
                failures++;
                $display("FAIL unpause k=%0d: pu=%b dim=%b required %b",
                         k, pause_user, dim_video, (k < 7));
            end
            if (k == 8) begin
                checks++;
                if (rgb_out !== 8'hA5) begin
                    failures++;
                    $display("FAIL unpause_rgb: rgb=%h required a5", rgb_out);
                end
            end
        end
        pause_btn = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_glitch();
        do_reset();
        pause_btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 2) pause_btn = 1'b0;
            checks++;
            if (pause_user !== 1'b0) begin
                failures++;
                $display("FAIL glitch k=%0d: pu=%b required 0", k, pause_user);
            end
        end
        pause_btn = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 6 || k == 7) begin
                checks++;
                if (pause_user !== (k == 7)) begin
                    failures++;
                    $display("FAIL glitch_after k=%0d: pu=%b required %b",
                             k, pause_user, (k == 7));
                end
            end
        end
        pause_btn = 1'b0;
    endtask

    task automatic test_hs_access();
        do_reset();
        hs_access = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            checks++;
            if (pause !== 1'b1 || pause_user !== 1'b0 || dim_video !== 1'b0) begin
                failures++;
                $display("FAIL hs k=%0d: p=%b pu=%b dim=%b required 1 0 0",
                         k, pause, pause_user, dim_video);
            end
        end
        hs_access = 1'b0;
        #1;
        checks++;
        if (pause !== 1'b0) begin
            failures++;
            $display("FAIL hs_release: pause=%b required 0", pause);
        end
    endtask

    task automatic test_osd();
        do_reset();
        osd_open = 1'b1;
        osd_pause_en = 1'b0;
        #1;
        checks++;
        if (pause !== 1'b0) begin
            failures++;
            $display("FAIL osd_dis: pause=%b required 0", pause);
        end
        osd_pause_en = 1'b1;
        #1;
        checks++;
        if (pause !== 1'b1) begin
            failures++;
            $display("FAIL osd_en: pause=%b required 1", pause);
        end
        repeat (15) step();
        checks++;
        if (pause_user !== 1'b0 || dim_video !== 1'b0) begin
            failures++;
            $display("FAIL osd_fsm: pu=%b dim=%b required 0 0",
                     pause_user, dim_video);
        end
        osd_open = 1'b0;
        osd_pause_en = 1'b0;
    endtask

    task automatic test_reset_dimmed();
        do_reset();
        rgb_in = 8'h3C;
        pause_btn = 1'b1;
        repeat (19) step();
        checks++;
        if (dim_video !== 1'b1) begin
            failures++;
            $display("FAIL rd_pre: dim=%b required 1", dim_video);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (pause_user !== 1'b0 || dim_video !== 1'b0 ||
            rgb_out !== 8'h00 || pause !== 1'b0) begin
            failures++;
            $display("FAIL rd_reset: p=%b pu=%b dim=%b rgb=%h required 0 0 0 00",
                     pause, pause_user, dim_video, rgb_out);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (pause_user !== (k >= 7)) begin
                failures++;
                $display("FAIL rd_held k=%0d: pu=%b required %b",
                         k, pause_user, (k >= 7));
            end
        end
        pause_btn = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        logic exp_pause;
        hold = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step();
            exp_pause = hs_access | (m_mode != 0) | (osd_open & osd_pause_en);
            checks++;
            if (pause_user !== (m_mode != 0) || dim_video !== (m_mode == 2) ||
                rgb_out !== m_rgb || pause !== exp_pause) begin
                failures++;
                $display("FAIL rand n=%0d: pu=%b dim=%b rgb=%h p=%b required %b %b %h %b",
                         n, pause_user, dim_video, rgb_out, pause,
                         (m_mode != 0), (m_mode == 2), m_rgb, exp_pause);
            end
            if (hold == 0) begin
                pause_btn = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 14);
            end
            hold--;
            rgb_in = 8'($urandom);
            hs_access = ($urandom_range(0, 7) == 0);
            osd_open = 1'($urandom_range(0, 1));
            osd_pause_en = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 299) != 0);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_press_dim();
        test_unpause();
        test_glitch();
        test_hs_access();
        test_osd();
        test_reset_dimmed();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pause_ctrl.md
PAUSE_CTRL -- requirements
Module: pause_ctrl

Interface
REQ-001 SHALL have parameter DIM_CYCLES, default 32'h0E4E1C00, cycles spent in PAUSED before dimming.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16'd1200, consecutive stable cycles needed to accept a pause-button level change (DEBOUNCE_CYCLES >= 1).
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pause_btn  input  1  raw joystick pause button, active-high, asynchronous to clk_sys.
REQ-006 SHALL have port osd_open  input  1  OSD-visible flag.
REQ-007 SHALL have port osd_pause_en  input  1  enables pausing while the OSD is open.
REQ-008 SHALL have port hs_access  input  1  hiscore module requests exclusive RAM access.
REQ-009 SHALL have port rgb_in  input  8  pixel {r[2:0],g[2:0],b[1:0]}.
REQ-010 SHALL have port pause  output  1  core pause request.
REQ-011 SHALL have port pause_user  output  1  user-toggled pause state.
REQ-012 SHALL have port dim_video  output  1  dimming active.
REQ-013 SHALL have port rgb_out  output  8  possibly dimmed pixel.

Function
REQ-014 SHALL pass pause_btn through a 2-flop synchronizer before any other use.
REQ-015 Debouncer: SHALL count consecutive cycles where the synchronized level differs from the debounced level, and SHALL clear the count on any cycle they match.
REQ-016 Debouncer: SHALL load the synchronized level into the debounced level on the cycle the differing run reaches DEBOUNCE_CYCLES, clearing the count at the same time.
REQ-017 SHALL register the debounced level, and SHALL act on a rising edge exactly one cycle after the debounced level rises; falling edges SHALL have no effect.
REQ-018 Latency: a raw press held stable SHALL toggle pause_user exactly DEBOUNCE_CYCLES+3 cycles after the first sampling edge that captures it.
REQ-019 FSM states SHALL be RUN, PAUSED and DIMMED; pause_user SHALL be 0 in RUN and 1 in PAUSED and DIMMED; dim_video SHALL be 1 only in DIMMED.
REQ-020 RUN + press event -> PAUSED, with the 32-bit timer cleared.
REQ-021 PAUSED: the timer SHALL increment by 1 each cycle; on the cycle it equals DIM_CYCLES the FSM SHALL go to DIMMED.
REQ-022 PAUSED: if DIM_CYCLES=0, the FSM SHALL reach DIMMED one cycle after entering PAUSED.
REQ-023 PAUSED or DIMMED + press event -> RUN, with the timer cleared; a press SHALL take priority over the timer in the same cycle.
REQ-024 DIMMED: the timer SHALL hold; it SHALL never wrap.
REQ-025 pause SHALL be combinational: hs_access | pause_user | (osd_open & osd_pause_en).
REQ-026 hs_access and the OSD pause SHALL NOT start or affect the timer or the FSM.
REQ-027 rgb_out SHALL be registered with 1-cycle latency.
REQ-028 When dim_video=1, rgb_out SHALL be {1'b0,r[2:1],1'b0,g[2:1],1'b0,b[1]}; otherwise rgb_out SHALL equal rgb_in. The dim_video value sampled is the one in the same cycle as rgb_in.

Reset
REQ-029 On reset_n=0 at a clock edge: FSM SHALL be RUN; timer, debounce count, synchronizer flops, debounced level, edge register, pause_user, dim_video and rgb_out SHALL all be 0.
REQ-030 pause SHALL follow REQ-025 during reset, with pause_user=0.
REQ-031 Reset asserted while in PAUSED or DIMMED SHALL return to RUN with no dimming on the next cycle.
REQ-032 A button held through reset SHALL register as one press, DEBOUNCE_CYCLES+3 cycles after reset_n goes high.

Verification (DIM_CYCLES=10, DEBOUNCE_CYCLES=4)
REQ-033 Press held 20 cycles -> pause_user=1 at cycle 7; dim_video=1 at cycle 18; rgb_in=8'hFF -> rgb_out=8'h6D one cycle later.
REQ-034 3-cycle glitch on pause_btn -> pause_user stays 0; debounce count returns to 0.
REQ-035 In DIMMED, press again -> pause_user=0 and dim_video=0 after 7 cycles; rgb_out follows rgb_in unchanged.
REQ-036 hs_access=1 for 50 cycles in RUN -> pause=1 throughout; pause_user=0; dim_video never asserts.
REQ-037 osd_open=1 with osd_pause_en=0 -> pause=0; then osd_pause_en=1 -> pause=1 in the same cycle.
REQ-038 Assert reset_n=0 in DIMMED -> next edge: RUN, all outputs 0; button held through reset -> pause_user=1 seven cycles after release of reset.
